// File: rtl/mhsa_pkg.sv
// Shared constants and types for the MHSA unified SRAM (USRAM) and its arbiter.
package mhsa_pkg;

    localparam int USRAM_WIDTH = 64;
    localparam int USRAM_DEPTH = 4096;
    localparam int USRAM_AW    = $clog2(USRAM_DEPTH);

    typedef enum logic {
        OWN_SOC = 1'b0,
        OWN_ACC = 1'b1
    } owner_e;

endpackage

// File: rtl/usram_rr_arb2.sv
// Two-way round-robin grant logic for the USRAM arbiter, holding the last_owner register.
module usram_rr_arb2
    import mhsa_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic soc_req,
    input  logic acc_req,
    input  logic upd_en,
    output logic soc_gnt,
    output logic acc_gnt
);

    owner_e last_owner_reg;
    owner_e last_owner_next;

    always_comb begin
        soc_gnt         = 1'b0;
        acc_gnt         = 1'b0;
        last_owner_next = last_owner_reg;
        if (!rst) begin
            if (soc_req && acc_req) begin
                // On a tie the requester that did not win last time goes first.
                if (last_owner_reg == OWN_ACC) begin
                    soc_gnt = 1'b1;
                end else begin
                    acc_gnt = 1'b1;
                end
            end else begin
                soc_gnt = soc_req;
                acc_gnt = acc_req;
            end
        end
        if (upd_en) begin
            if (soc_gnt) begin
                last_owner_next = OWN_SOC;
            end else if (acc_gnt) begin
                last_owner_next = OWN_ACC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_reg <= OWN_ACC;
        end else begin
            last_owner_reg <= last_owner_next;
        end
    end

endmodule

// File: rtl/usram_arbiter.sv
// Round-robin arbiter sharing the single-port USRAM between the SoC bridge and the MHSA datapath.
// Optional grant/conflict counters are built when USRAM_ARBITER_PERF_EN is defined.
module usram_arbiter
    import mhsa_pkg::*;
#(
    parameter int WIDTH = USRAM_WIDTH,
    parameter int DEPTH = USRAM_DEPTH,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     soc_req,
    input  logic                     soc_we,
    input  logic [AW-1:0]            soc_addr,
    input  logic [WIDTH-1:0]         soc_wdata,
    output logic                     soc_gnt,
    output logic                     soc_rvalid,
    output logic [WIDTH-1:0]         soc_rdata,
    output logic                     soc_err,
    input  logic                     acc_req,
    input  logic                     acc_we,
    input  logic [AW-1:0]            acc_addr,
    input  logic [WIDTH-1:0]         acc_wdata,
    output logic                     acc_gnt,
    output logic                     acc_rvalid,
    output logic [WIDTH-1:0]         acc_rdata,
`ifdef USRAM_ARBITER_PERF_EN
    input  logic                     perf_clr,
    output logic [31:0]              soc_gnt_cnt,
    output logic [31:0]              acc_gnt_cnt,
    output logic [31:0]              conflict_cnt,
`endif
    output logic                     sram_en,
    output logic                     sram_we,
    output logic [$clog2(DEPTH)-1:0] sram_addr,
    output logic [WIDTH-1:0]         sram_wdata,
    input  logic [WIDTH-1:0]         sram_rdata
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic       arb_soc_gnt;
    logic       arb_acc_gnt;
    logic       soc_oor;
    logic       soc_err_int;
    logic       unused_acc_addr_hi;

    logic             rd_pend_reg;
    owner_e           rd_owner_reg;
    logic [WIDTH-1:0] soc_hold_reg;
    logic [WIDTH-1:0] acc_hold_reg;

    assign soc_oor            = (soc_addr >= AW'(DEPTH));
    assign soc_err_int        = arb_soc_gnt && soc_oor;
    // ACC is trusted: upper address bits are simply dropped.
    assign unused_acc_addr_hi = ^acc_addr[AW-1:ADDR_W];

    usram_rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .soc_req (soc_req),
        .acc_req (acc_req),
        .upd_en  (!soc_err_int),
        .soc_gnt (arb_soc_gnt),
        .acc_gnt (arb_acc_gnt)
    );

    always_comb begin
        soc_gnt    = arb_soc_gnt;
        acc_gnt    = arb_acc_gnt;
        soc_err    = soc_err_int;
        sram_en    = (arb_soc_gnt && !soc_oor) || arb_acc_gnt;
        sram_we    = acc_we;
        sram_addr  = acc_addr[ADDR_W-1:0];
        sram_wdata = acc_wdata;
        if (arb_soc_gnt) begin
            sram_we    = soc_we;
            sram_addr  = soc_addr[ADDR_W-1:0];
            sram_wdata = soc_wdata;
        end
    end

    // Read return: rvalid/rdata are steered in the cycle sram_rdata is valid,
    // and the hold registers keep each side's last word afterwards.
    always_comb begin
        soc_rvalid = !rst && rd_pend_reg && (rd_owner_reg == OWN_SOC);
        acc_rvalid = !rst && rd_pend_reg && (rd_owner_reg == OWN_ACC);
        soc_rdata  = soc_hold_reg;
        acc_rdata  = acc_hold_reg;
        if (rst) begin
            soc_rdata = '0;
            acc_rdata = '0;
        end else begin
            if (soc_rvalid) soc_rdata = sram_rdata;
            if (acc_rvalid) acc_rdata = sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_reg  <= 1'b0;
            rd_owner_reg <= OWN_SOC;
            soc_hold_reg <= '0;
            acc_hold_reg <= '0;
        end else begin
            rd_pend_reg  <= sram_en && !sram_we;
            rd_owner_reg <= arb_acc_gnt ? OWN_ACC : OWN_SOC;
            if (soc_rvalid) soc_hold_reg <= sram_rdata;
            if (acc_rvalid) acc_hold_reg <= sram_rdata;
        end
    end

`ifdef USRAM_ARBITER_PERF_EN
    logic [2:0]  cnt_inc;
    logic [31:0] cnt_reg [3];

    assign cnt_inc = {soc_req && acc_req, arb_acc_gnt, arb_soc_gnt && !soc_oor};

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst || perf_clr) begin
                cnt_reg[gi] <= '0;
            end else if (cnt_inc[gi] && (cnt_reg[gi] != 32'hFFFF_FFFF)) begin
                cnt_reg[gi] <= cnt_reg[gi] + 32'd1;
            end
        end
    end

    assign soc_gnt_cnt  = cnt_reg[0];
    assign acc_gnt_cnt  = cnt_reg[1];
    assign conflict_cnt = cnt_reg[2];
`endif

endmodule
